// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
//   Definitions shared by the RV32 front end.
//   XLEN       : width of the PC and of an instruction word
//   NOP_INST   : canonical NOP (addi x0,x0,0). ID substitutes it when id_valid=0.
//   fq_entry_t : one fetch-queue slot {pc, inst, filled}
// -----------------------------------------------------------------------------
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

   // filled=1 means inst holds the imem response for pc.
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
      logic            filled;
   } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Circular reservation buffer between the imem request and the ID stage.
//   An entry is allocated (pc known, inst pending) when a request is accepted,
//   filled in request order when its response returns, and popped from the
//   head once filled and taken by ID.
//
//   Ports
//     clk, rst        : clock, asynchronous active-low reset
//     alloc, alloc_pc : reserve the tail entry for pc alloc_pc
//     fill, fill_inst : write inst into the oldest unfilled entry
//     pop             : release the head entry (only honoured when filled)
//     flush           : drop every entry and return the pointers to 0
//     head            : current head entry (all zero when reset/flushed)
//     count           : number of allocated entries, 0..DEPTH
//     unfilled        : number of allocated entries still waiting for inst
// -----------------------------------------------------------------------------
module fetch_queue
   import core_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alloc,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill,
   input  logic [XLEN-1:0] fill_inst,
   input  logic            pop,
   input  logic            flush,
   output fq_entry_t       head,
   output logic [CW-1:0]   count,
   output logic [CW-1:0]   unfilled
);

   fq_entry_t       mem [DEPTH];
   logic [PW-1:0]   head_ptr;
   logic [PW-1:0]   tail_ptr;
   logic [PW-1:0]   fill_ptr;

   logic            full;
   logic            alloc_ok;
   logic            fill_ok;
   logic            pop_ok;

   // Local guards make the buffer safe against an illegal request from the
   // surrounding logic: no allocation when full, no fill with nothing pending,
   // no pop of an entry whose instruction has not arrived.
   assign full     = (count == CW'(DEPTH));
   assign alloc_ok = alloc && !full;
   assign fill_ok  = fill && (unfilled != '0);
   assign pop_ok   = pop && mem[head_ptr].filled;

   assign head = mem[head_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         count    <= '0;
         unfilled <= '0;
      end else if (flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         head_ptr <= '0;
         tail_ptr <= '0;
         fill_ptr <= '0;
         count    <= '0;
         unfilled <= '0;
      end else begin
         // Alloc, fill and pop always address distinct slots: alloc targets
         // an unallocated slot, fill an allocated-unfilled one, pop a filled one.
         if (alloc_ok) begin
            mem[tail_ptr].pc     <= alloc_pc;
            mem[tail_ptr].inst   <= '0;
            mem[tail_ptr].filled <= 1'b0;
            tail_ptr             <= tail_ptr + 1'b1;
         end
         if (fill_ok) begin
            mem[fill_ptr].inst   <= fill_inst;
            mem[fill_ptr].filled <= 1'b1;
            fill_ptr             <= fill_ptr + 1'b1;
         end
         if (pop_ok) begin
            // Clearing filled keeps a wrapped-around empty head from looking valid.
            mem[head_ptr].filled <= 1'b0;
            head_ptr             <= head_ptr + 1'b1;
         end
         count    <= count + CW'(alloc_ok) - CW'(pop_ok);
         unfilled <= unfilled + CW'(alloc_ok) - CW'(fill_ok);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage: issues in-order requests for pc_in to a
//   variable-latency imem, buffers {pc, inst} pairs in fetch_queue and hands
//   them to ID over a valid/ready handshake. It stalls the PC register unless
//   a request is accepted, and on a redirect flushes the queue and counts the
//   in-flight responses that must be thrown away.
//
//   Handshakes: a transfer happens on a cycle where valid && ready are both 1
//   at the rising clock edge; valid never depends on ready. imem responses are
//   returned in request order and cannot be back-pressured.
//
//   Ports
//     clk, rst        : clock, asynchronous active-low reset
//     pc_in           : current PC from the PC register
//     pc_stall        : 1 holds the PC register
//     flush           : redirect from EX (PC mux loads the target this cycle)
//     imem_req_*      : fetch request channel (valid/ready/addr)
//     imem_rsp_*      : fetch response (valid/data)
//     id_valid/ready  : handshake to ID
//     id_pc, id_inst  : head entry contents
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter int FQ_DEPTH = 4,
   // Must equal core_pkg::XLEN; the queue entry type is sized from the package.
   parameter int XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_stall,
   input  logic            flush,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_inst
);

   import core_pkg::*;

   localparam int CW = $clog2(FQ_DEPTH) + 1;
   // Several redirects can land while imem is still holding old requests, so
   // the discard counter is wider than one queue's worth of outstanding fetches.
   localparam int DW = CW + 4;

   fq_entry_t       head;
   logic [CW-1:0]   count;
   logic [CW-1:0]   unfilled;
   logic [DW-1:0]   discard_cnt;
   logic [DW-1:0]   discard_sum;

   logic            req_fire;
   logic            rsp_drop;
   logic            rsp_fill;
   logic            pop;

   // ---------------------------------------------------------------- request
   assign imem_req_valid = rst && !flush && (count < CW'(FQ_DEPTH));
   assign imem_req_addr  = pc_in;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // The PC moves once per accepted request; during a flush the PC mux must
   // load the redirect target, so the stall is released.
   assign pc_stall = !req_fire && !flush;

   // --------------------------------------------------------------- response
   // Stale responses are always older than any live request, so while
   // discard_cnt is non-zero every response is stale. A response with nothing
   // outstanding is ignored.
   assign rsp_drop = imem_rsp_valid && (discard_cnt != '0);
   assign rsp_fill = imem_rsp_valid && (discard_cnt == '0) && (unfilled != '0)
                     && !flush;

   // ----------------------------------------------------------------- output
   assign id_valid = head.filled;
   assign id_pc    = head.pc;
   assign id_inst  = head.inst;
   assign pop      = id_valid && id_ready && !flush;

   // ---------------------------------------------------------------- discard
   // On a flush every allocated-unfilled entry becomes a stale in-flight
   // response; a response arriving in the flush cycle itself is one of them
   // (or one already counted) and is consumed right away.
   assign discard_sum = discard_cnt + DW'(unfilled);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         discard_cnt <= '0;
      end else if (flush) begin
         if (imem_rsp_valid && (discard_sum != '0)) begin
            discard_cnt <= discard_sum - 1'b1;
         end else begin
            discard_cnt <= discard_sum;
         end
      end else if (rsp_drop) begin
         discard_cnt <= discard_cnt - 1'b1;
      end
   end

   // ------------------------------------------------------------------ queue
   fetch_queue #(
      .DEPTH (FQ_DEPTH)
   ) u_fetch_queue (
      .clk       (clk),
      .rst       (rst),
      .alloc     (req_fire),
      .alloc_pc  (pc_in),
      .fill      (rsp_fill),
      .fill_inst (imem_rsp_data),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (count),
      .unfilled  (unfilled)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed sequence plus a random phase for fetch_unit. The bench plays the
//   PC register and an in-order variable-latency imem; exp_q holds the PCs of
//   accepted requests in order, and each ID handshake is checked against it.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_stall;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_inst;

   always #5 clk = ~clk;

   fetch_unit #(
      .FQ_DEPTH (DEPTH),
      .XLEN     (32)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .pc_stall       (pc_stall),
      .flush          (flush),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_inst        (id_inst)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mem_q[$];
   logic [31:0] exp_q[$];
   int          m_filled;
   int          m_disc;
   int          cyc;
   int          last_due;
   int          n_chk;
   int          n_pass;
   logic        g_req_ready;
   logic        g_id_ready;
   int          g_lat;
   logic [31:0] last_pop;
   logic        have_last;
   logic        want_first;
   logic [31:0] first_pc;
   int          pops;
   int          acc_10;
   int          acc_cnt;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // One clock cycle: drive inputs just after the edge, check outputs 2 time
   // units later, update the models, then advance past the next rising edge.
   task automatic step(input logic fl, input logic [31:0] tgt);
      logic        e_req;
      logic        e_stall;
      logic        e_idv;
      logic        pop;
      logic        fill;
      int          unf;
      int          due;
      logic [31:0] nxt_pc;
      flush          = fl;
      imem_req_ready = g_req_ready;
      id_ready       = g_id_ready;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mem_q[0].addr);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #2;
      e_req   = !fl && (exp_q.size() < DEPTH);
      e_stall = !(e_req && g_req_ready) && !fl;
      e_idv   = (m_filled > 0);
      chk("req_valid", imem_req_valid, e_req);
      chk("pc_stall", pc_stall, e_stall);
      chk("id_valid", id_valid, e_idv);
      if (imem_req_valid) chk("req_addr", imem_req_addr, pc_in);
      if (e_idv) begin
         chk("id_pc", id_pc, exp_q[0]);
         chk("id_inst", id_inst, mem_word(exp_q[0]));
      end
      unf  = exp_q.size() - m_filled;
      fill = 1'b0;
      if (fl) begin
         if (imem_rsp_valid) chk("rsp_outstanding", (m_disc + unf > 0), 1);
         m_disc = m_disc + unf - (imem_rsp_valid ? 1 : 0);
         if (m_disc < 0) m_disc = 0;
         exp_q.delete();
         m_filled   = 0;
         have_last  = 1'b0;
         want_first = 1'b1;
      end else begin
         if (imem_rsp_valid) begin
            if (m_disc > 0) m_disc--;
            else begin
               chk("rsp_outstanding", (unf > 0), 1);
               fill = (unf > 0);
            end
         end
         pop = e_idv && g_id_ready;
         if (pop) begin
            pops++;
            if (have_last) chk("pc_seq", id_pc, last_pop + 32'd4);
            if (want_first) begin
               first_pc   = id_pc;
               want_first = 1'b0;
            end
            last_pop  = exp_q[0];
            have_last = 1'b1;
            void'(exp_q.pop_front());
         end
         m_filled = m_filled + (fill ? 1 : 0) - (pop ? 1 : 0);
         if (e_req && g_req_ready) exp_q.push_back(pc_in);
      end
      // imem model reacts to what the DUT actually issued
      if (imem_rsp_valid) void'(mem_q.pop_front());
      if (imem_req_valid && imem_req_ready) begin
         due = cyc + 1 + g_lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: pc_in, due: due});
         acc_cnt++;
         if (pc_in == 32'h10) acc_10++;
      end
      nxt_pc = fl ? tgt : (pc_stall ? pc_in : pc_in + 32'd4);
      @(posedge clk);
      #1;
      pc_in = nxt_pc;
      cyc++;
   endtask

   task automatic check_reset_outputs();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_pc_stall", pc_stall, 1);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_inst", id_inst, 0);
      chk("rst_discard", dut.discard_cnt, 0);
   endtask

   task automatic do_reset();
      rst            = 1'b0;
      flush          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      id_ready       = 1'b0;
      pc_in          = '0;
      #1;
      check_reset_outputs();
      exp_q.delete();
      mem_q.delete();
      m_filled   = 0;
      m_disc     = 0;
      have_last  = 1'b0;
      want_first = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cyc      = cyc + 2;
      last_due = cyc;
      check_reset_outputs();
      rst = 1'b1;
   endtask

   // Idle the request side until every stale and live fetch has drained.
   task automatic settle();
      int n;
      g_req_ready = 1'b0;
      g_id_ready  = 1'b1;
      n = 0;
      while ((mem_q.size() > 0 || exp_q.size() > 0 || m_disc > 0) && n < 100) begin
         step(1'b0, '0);
         n++;
      end
      chk("settle_in_time", (n < 100), 1);
      chk("settle_discard", dut.discard_cnt, 0);
   endtask

   int p0;

   initial begin
      rst = 1'b0; flush = 1'b0; pc_in = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;
      n_chk = 0; n_pass = 0; cyc = 0; last_due = 0; pops = 0; acc_10 = 0; acc_cnt = 0;
      g_req_ready = 1'b0; g_id_ready = 1'b0; g_lat = 0;
      first_pc = '1; last_pop = '0; have_last = 1'b0; want_first = 1'b0;
      @(posedge clk);
      #1;

      // Reset, then stream with zero-latency imem: one instruction per cycle.
      do_reset();
      g_req_ready = 1'b1; g_id_ready = 1'b1; g_lat = 0;
      p0 = pops;
      repeat (12) step(1'b0, '0);
      chk("stream_pops", pops - p0, 10);
      chk("stream_first_pc", first_pc, 32'h0);

      // imem not ready for 3 cycles at 0x10.
      settle();
      step(1'b1, 32'h10);
      acc_10 = 0;
      g_req_ready = 1'b0;
      repeat (3) step(1'b0, '0);
      chk("pc_held_0x10", pc_in, 32'h10);
      g_req_ready = 1'b1;
      repeat (6) step(1'b0, '0);
      chk("req_0x10_once", acc_10, 1);

      // Full queue with ID stalled, reset taken mid-operation.
      do_reset();
      acc_cnt = 0;
      g_req_ready = 1'b1; g_id_ready = 1'b0; g_lat = 0;
      repeat (8) step(1'b0, '0);
      chk("full_accepts", acc_cnt, 4);
      chk("full_req_valid", imem_req_valid, 0);
      chk("full_pc_stall", pc_stall, 1);
      chk("full_id_valid", id_valid, 1);
      chk("full_id_pc", id_pc, 32'h0);
      g_id_ready = 1'b1;
      repeat (10) step(1'b0, '0);
      chk("drain_first_pc", first_pc, 32'h0);

      // Flush with two requests outstanding at 3-cycle latency.
      settle();
      step(1'b1, 32'h20);
      g_req_ready = 1'b1; g_lat = 3;
      step(1'b0, '0);
      step(1'b0, '0);
      g_req_ready = 1'b0;
      step(1'b1, 32'h100);
      chk("flush2_discard", dut.discard_cnt, 2);
      g_req_ready = 1'b1; g_lat = 0; g_id_ready = 1'b1;
      repeat (8) step(1'b0, '0);
      chk("flush2_discard_done", dut.discard_cnt, 0);
      chk("flush2_first_pc", first_pc, 32'h100);

      // Flush in the same cycle as the response for 0x40, 0x44 in flight.
      settle();
      step(1'b1, 32'h40);
      g_req_ready = 1'b1; g_lat = 2;
      step(1'b0, '0);
      step(1'b0, '0);
      g_req_ready = 1'b0;
      step(1'b0, '0);
      step(1'b1, 32'h200);
      chk("flush_rsp_discard", dut.discard_cnt, 1);
      g_req_ready = 1'b1; g_lat = 0; g_id_ready = 1'b1;
      repeat (8) step(1'b0, '0);
      chk("flush_rsp_discard_done", dut.discard_cnt, 0);
      chk("flush_rsp_first_pc", first_pc, 32'h200);

      // Random latency, back-pressure and redirects.
      settle();
      for (int i = 0; i < 2000; i++) begin
         logic        fl;
         logic [31:0] tgt;
         if (i == 1000) do_reset();
         g_req_ready = ($urandom_range(0, 3) != 0);
         g_id_ready  = ($urandom_range(0, 3) != 0);
         g_lat       = $urandom_range(0, 5);
         fl          = ($urandom_range(0, 39) == 0);
         tgt         = 32'($urandom_range(0, 32'h3FFF)) << 2;
         step(fl, tgt);
      end
      settle();
      chk("final_id_valid", id_valid, 0);
      chk("final_model_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
